axi_lite_xbar: RTL



---
 rtl/axi_pkg.sv | 31 +++
 rtl/axi_lite_addr_dec.sv | 37 +++
 rtl/axi_lite_xbar.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI4-Lite crossbar.
// Contents:
//   RESP_*      : AXI response codes
//   rd_state_e  : read-path FSM states
//   wr_state_e  : write-path FSM states
//   idx_width() : width of a slave index (at least 1 bit)
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA,
        R_ERR
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_FWD,
        W_RESP,
        W_ERR
    } wr_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_addr_dec.sv
// Combinational base/mask address decoder.
// Ports:
//   addr : address to decode
//   hit  : one-hot slave hit (all zero on miss)
//   idx  : binary index of the selected slave (0 on miss)
//   miss : no window matched
// The lowest slave index wins when windows overlap.
module axi_lite_addr_dec
    import axi_pkg::*;
#(
    parameter int unsigned           N_SLV    = 2,
    parameter logic [N_SLV*32-1:0]   SLV_BASE = {32'hA000_03F8, 32'h8000_0000},
    parameter logic [N_SLV*32-1:0]   SLV_MASK = {32'hFFFF_FFF8, 32'hF800_0000},
    localparam int unsigned          IDX_W    = idx_width(N_SLV)
) (
    input  logic [31:0]      addr,
    output logic [N_SLV-1:0] hit,
    output logic [IDX_W-1:0] idx,
    output logic             miss
);

    always_comb begin
        hit  = '0;
        idx  = '0;
        miss = 1'b1;
        // Walk downwards so the lowest matching index is the last writer.
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32])) begin
                hit    = '0;
                hit[i] = 1'b1;
                idx    = IDX_W'(i);
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_lite_xbar.sv
// 1-to-N AXI4-Lite crossbar with internal DECERR for unmapped addresses.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   u_ar*/u_r*        : upstream read address / data channels
//   u_aw*/u_w*/u_b*   : upstream write address / data / response channels
//   d_ar*/d_r*        : downstream read channels (per-slave valid/ready, shared address)
//   d_aw*/d_w*/d_b*   : downstream write channels (per-slave valid/ready, shared addr/data)
// Read and write paths are independent, each with one outstanding transaction.
module axi_lite_xbar
    import axi_pkg::*;
#(
    parameter int unsigned         N_SLV    = 2,
    parameter logic [N_SLV*32-1:0] SLV_BASE = {32'hA000_03F8, 32'h8000_0000},
    parameter logic [N_SLV*32-1:0] SLV_MASK = {32'hFFFF_FFF8, 32'hF800_0000}
) (
    input  logic                 clk,
    input  logic                 rst,
    // upstream read
    input  logic                 u_arvalid,
    output logic                 u_arready,
    input  logic [31:0]          u_araddr,
    output logic                 u_rvalid,
    input  logic                 u_rready,
    output logic [31:0]          u_rdata,
    output logic [1:0]           u_rresp,
    // upstream write
    input  logic                 u_awvalid,
    output logic                 u_awready,
    input  logic [31:0]          u_awaddr,
    input  logic                 u_wvalid,
    output logic                 u_wready,
    input  logic [31:0]          u_wdata,
    input  logic [3:0]           u_wstrb,
    output logic                 u_bvalid,
    input  logic                 u_bready,
    output logic [1:0]           u_bresp,
    // downstream read
    output logic [N_SLV-1:0]     d_arvalid,
    input  logic [N_SLV-1:0]     d_arready,
    output logic [31:0]          d_araddr,
    input  logic [N_SLV-1:0]     d_rvalid,
    output logic [N_SLV-1:0]     d_rready,
    input  logic [N_SLV*32-1:0]  d_rdata,
    input  logic [N_SLV*2-1:0]   d_rresp,
    // downstream write
    output logic [N_SLV-1:0]     d_awvalid,
    input  logic [N_SLV-1:0]     d_awready,
    output logic [31:0]          d_awaddr,
    output logic [N_SLV-1:0]     d_wvalid,
    input  logic [N_SLV-1:0]     d_wready,
    output logic [31:0]          d_wdata,
    output logic [3:0]           d_wstrb,
    input  logic [N_SLV-1:0]     d_bvalid,
    output logic [N_SLV-1:0]     d_bready,
    input  logic [N_SLV*2-1:0]   d_bresp
);

    localparam int unsigned IDX_W = idx_width(N_SLV);

    logic [N_SLV-1:0] rd_hit, wr_hit;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             rd_miss, wr_miss;

    rd_state_e        rstate;
    logic [31:0]      raddr;
    logic [IDX_W-1:0] rsel;

    wr_state_e        wstate;
    logic [31:0]      waddr;
    logic [IDX_W-1:0] wsel;
    logic             aw_done, w_done;
    logic             aw_fire, w_fire;

    // Only the binary index is needed here; the one-hot form is left unconsumed.
    logic unused_hit;
    assign unused_hit = ^{rd_hit, wr_hit};

    axi_lite_addr_dec #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_rd_dec (
        .addr (u_araddr),
        .hit  (rd_hit),
        .idx  (rd_idx),
        .miss (rd_miss)
    );

    axi_lite_addr_dec #(
        .N_SLV    (N_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_wr_dec (
        .addr (u_awaddr),
        .hit  (wr_hit),
        .idx  (wr_idx),
        .miss (wr_miss)
    );

    // ---------------------------------------------------------------- read path
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            raddr  <= '0;
            rsel   <= '0;
        end else begin
            unique case (rstate)
                R_IDLE: begin
                    if (u_arvalid) begin
                        raddr  <= u_araddr;
                        rsel   <= rd_idx;
                        rstate <= rd_miss ? R_ERR : R_ADDR;
                    end
                end
                R_ADDR: if (d_arready[rsel])              rstate <= R_DATA;
                R_DATA: if (d_rvalid[rsel] && u_rready)   rstate <= R_IDLE;
                R_ERR:  if (u_rready)                     rstate <= R_IDLE;
                default:                                  rstate <= R_IDLE;
            endcase
        end
    end

    assign d_araddr = raddr;

    always_comb begin
        u_arready = 1'b0;
        u_rvalid  = 1'b0;
        u_rdata   = '0;
        u_rresp   = RESP_OKAY;
        d_arvalid = '0;
        d_rready  = '0;
        if (!rst) begin
            unique case (rstate)
                R_IDLE: u_arready = 1'b1;
                R_ADDR: d_arvalid[rsel] = 1'b1;
                R_DATA: begin
                    u_rvalid       = d_rvalid[rsel];
                    d_rready[rsel] = u_rready;
                    if (d_rvalid[rsel]) begin
                        u_rdata = d_rdata[32*rsel +: 32];
                        u_rresp = d_rresp[2*rsel +: 2];
                    end
                end
                R_ERR: begin
                    u_rvalid = 1'b1;
                    u_rresp  = RESP_DECERR;
                end
                default: ;
            endcase
        end
    end

    // --------------------------------------------------------------- write path
    assign aw_fire = (wstate == W_FWD) && !aw_done && d_awready[wsel];
    assign w_fire  = (wstate == W_FWD) && !w_done && u_wvalid && d_wready[wsel];

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate  <= W_IDLE;
            waddr   <= '0;
            wsel    <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            unique case (wstate)
                W_IDLE: begin
                    if (u_awvalid) begin
                        waddr   <= u_awaddr;
                        wsel    <= wr_idx;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        wstate  <= wr_miss ? W_ERR : W_FWD;
                    end
                end
                W_FWD: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (w_fire)  w_done  <= 1'b1;
                    // Same-cycle completion of the last channel counts as done.
                    if ((aw_done || aw_fire) && (w_done || w_fire)) wstate <= W_RESP;
                end
                W_RESP: if (d_bvalid[wsel] && u_bready) wstate <= W_IDLE;
                W_ERR: begin
                    // Swallow the data beat first, then present DECERR.
                    if (!w_done) begin
                        if (u_wvalid) w_done <= 1'b1;
                    end else if (u_bready) begin
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    assign d_awaddr = waddr;
    assign d_wdata  = u_wdata;
    assign d_wstrb  = u_wstrb;

    always_comb begin
        u_awready = 1'b0;
        u_wready  = 1'b0;
        u_bvalid  = 1'b0;
        u_bresp   = RESP_OKAY;
        d_awvalid = '0;
        d_wvalid  = '0;
        d_bready  = '0;
        if (!rst) begin
            unique case (wstate)
                W_IDLE: u_awready = 1'b1;
                W_FWD: begin
                    d_awvalid[wsel] = !aw_done;
                    d_wvalid[wsel]  = u_wvalid && !w_done;
                    u_wready        = d_wready[wsel] && !w_done;
                end
                W_RESP: begin
                    u_bvalid       = d_bvalid[wsel];
                    d_bready[wsel] = u_bready;
                    if (d_bvalid[wsel]) u_bresp = d_bresp[2*wsel +: 2];
                end
                W_ERR: begin
                    u_wready = !w_done;
                    u_bvalid = w_done;
                    if (w_done) u_bresp = RESP_DECERR;
                end
                default: ;
            endcase
        end
    end

endmodule
